block_window_loader: RTL and testbench

//  Producer side of the per-pixel block selector. Streams the beatmap from block ROM and

---
 rtl/block_pkg.sv | 48 ++++
 rtl/sliced_id_list.sv | 48 ++++
 rtl/block_window_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_block_window_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared types, sizes and helpers for the block window loader.
// Imported by the loader top and its sliced-ID list.
package block_pkg;

    localparam int NUM_SLOTS = 12;
    localparam int Z_W       = 14;
    localparam int CNT_W     = 4;
    localparam int WAIT_W    = 4;

    localparam logic [7:0]     ID_NONE = 8'hFF;
    localparam logic [Z_W-1:0] Z_MAX   = 14'h3FFF;

    // Bit layout matches the ROM word: {time, x, y, color, dir}.
    typedef struct packed {
        logic [17:0] t;
        logic [11:0] x;
        logic [11:0] y;
        logic        color;
        logic [2:0]  dir;
    } block_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RETIRE,
        ST_FILL,
        ST_FETCH,
        ST_ZCALC,
        ST_COMMIT
    } state_e;

    // Distance to the player plane; blocks already passed sit at z=0.
    function automatic logic [Z_W-1:0] calc_z(
        input logic [17:0] t_blk,
        input logic [17:0] t_now,
        input int unsigned zpt
    );
        logic [18:0] delta;
        logic [49:0] prod;
        delta  = {1'b0, t_blk} - {1'b0, t_now};
        prod   = '0;
        calc_z = '0;
        if (!delta[18]) begin
            prod   = {32'd0, delta[17:0]} * {18'd0, zpt};
            calc_z = (prod > 50'(Z_MAX)) ? Z_MAX : prod[Z_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sliced_id_list.sv
// Ring of recently sliced block IDs fed back to the selector.
// Duplicate IDs are ignored; the oldest entry is overwritten on wrap.
module sliced_id_list
    import block_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      restart_in,
    input  logic                      slice_valid_in,
    input  logic [7:0]                slice_id_in,
    output logic [NUM_SLOTS-1:0][7:0] list_out
);

    logic [NUM_SLOTS-1:0][7:0] list_q;
    logic [CNT_W-1:0]          wr_ptr_q;
    logic                      hit_d;

    // Look for the incoming ID anywhere in the ring.
    always_comb begin
        hit_d = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (list_q[i] == slice_id_in) begin
                hit_d = 1'b1;
            end
        end
    end

    // Store new IDs at the write pointer; restart clears the ring.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            list_q   <= {NUM_SLOTS{ID_NONE}};
            wr_ptr_q <= '0;
        end else if (restart_in) begin
            list_q   <= {NUM_SLOTS{ID_NONE}};
            wr_ptr_q <= '0;
        end else if (slice_valid_in && !hit_d) begin
            list_q[wr_ptr_q] <= slice_id_in;
            if (wr_ptr_q == CNT_W'(NUM_SLOTS - 1)) begin
                wr_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            end
        end
    end

    assign list_out = list_q;

endmodule

// File: rtl/block_window_loader.sv
// Streams the time-sorted beatmap and keeps the 12 nearest upcoming
// blocks; once per frame it publishes a stable window with z values.
module block_window_loader
    import block_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS  = 200,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned HORIZON     = 4096,
    parameter int unsigned Z_PER_TICK  = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        frame_start_in,
    input  logic                        restart_in,
    input  logic [17:0]                 curr_time_in,
    input  logic                        slice_valid_in,
    input  logic [7:0]                  slice_ID_in,
    output logic [7:0]                  rom_addr_out,
    input  logic [45:0]                 rom_data_in,
    output logic [NUM_SLOTS-1:0][11:0]  block_x_out,
    output logic [NUM_SLOTS-1:0][11:0]  block_y_out,
    output logic [NUM_SLOTS-1:0][13:0]  block_z_out,
    output logic [NUM_SLOTS-1:0]        block_color_out,
    output logic [NUM_SLOTS-1:0][2:0]   block_direction_out,
    output logic [NUM_SLOTS-1:0][7:0]   block_ID_out,
    output logic [NUM_SLOTS-1:0]        block_visible_out,
    output logic [NUM_SLOTS-1:0][7:0]   sliced_blocks_out,
    output logic                        busy_out,
    output logic                        window_valid_out
);

    state_e           state_q;
    logic [17:0]      t_now_q;
    logic [7:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0] zidx_q;
    logic             busy_q;
    logic             wvalid_q;
    logic [7:0]       rom_addr_q;

    // Private working window; slot 0 is the nearest block.
    block_rec_t       slot_q [NUM_SLOTS];
    logic [7:0]       wid_q  [NUM_SLOTS];

    // Staging copy built during ZCALC, copied out in COMMIT.
    logic [NUM_SLOTS-1:0][11:0]  stg_x_q;
    logic [NUM_SLOTS-1:0][11:0]  stg_y_q;
    logic [NUM_SLOTS-1:0][13:0]  stg_z_q;
    logic [NUM_SLOTS-1:0]        stg_c_q;
    logic [NUM_SLOTS-1:0][2:0]   stg_d_q;
    logic [NUM_SLOTS-1:0][7:0]   stg_id_q;
    logic [NUM_SLOTS-1:0]        stg_vis_q;

    // Published arrays, stable between commits.
    logic [NUM_SLOTS-1:0][11:0]  pub_x_q;
    logic [NUM_SLOTS-1:0][11:0]  pub_y_q;
    logic [NUM_SLOTS-1:0][13:0]  pub_z_q;
    logic [NUM_SLOTS-1:0]        pub_c_q;
    logic [NUM_SLOTS-1:0][2:0]   pub_d_q;
    logic [NUM_SLOTS-1:0][7:0]   pub_id_q;
    logic [NUM_SLOTS-1:0]        pub_vis_q;

    block_rec_t       rom_rec_d;
    block_rec_t       zsel_d;
    logic [Z_W-1:0]   z_d;
    logic             fits_d;
    logic             retire_d;
    logic             fill_done_d;
    logic             zlive_d;
    logic [7:0]       ptr_inc_d;
    logic [CNT_W-1:0] cnt_inc_d;

    assign rom_rec_d   = block_rec_t'(rom_data_in);
    assign fits_d      = {1'b0, rom_rec_d.t} <=
                         ({1'b0, t_now_q} + 19'(HORIZON));
    assign retire_d    = (cnt_q != '0) && (slot_q[0].t < t_now_q);
    assign fill_done_d = (cnt_q == CNT_W'(NUM_SLOTS)) ||
                         (ptr_q == 8'(NUM_BLOCKS));
    assign ptr_inc_d   = ptr_q + 8'd1;
    assign cnt_inc_d   = cnt_q + CNT_W'(1);
    assign zsel_d      = slot_q[zidx_q];
    assign zlive_d     = zidx_q < cnt_q;
    assign z_d         = calc_z(zsel_d.t, t_now_q, Z_PER_TICK);

    // Update sequencer: retire passed blocks, refill from ROM, compute z, publish.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            t_now_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            zidx_q     <= '0;
            busy_q     <= 1'b0;
            wvalid_q   <= 1'b0;
            rom_addr_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
                wid_q[i]  <= ID_NONE;
            end
            stg_x_q   <= '0;
            stg_y_q   <= '0;
            stg_z_q   <= '0;
            stg_c_q   <= '0;
            stg_d_q   <= '0;
            stg_id_q  <= {NUM_SLOTS{ID_NONE}};
            stg_vis_q <= '0;
            pub_x_q   <= '0;
            pub_y_q   <= '0;
            pub_z_q   <= '0;
            pub_c_q   <= '0;
            pub_d_q   <= '0;
            pub_id_q  <= {NUM_SLOTS{ID_NONE}};
            pub_vis_q <= '0;
        end else if (restart_in) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            wvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start_in) begin
                        t_now_q <= curr_time_in;
                        busy_q  <= 1'b1;
                        zidx_q  <= '0;
                        state_q <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    if (retire_d) begin
                        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                            slot_q[i] <= slot_q[i+1];
                            wid_q[i]  <= wid_q[i+1];
                        end
                        slot_q[NUM_SLOTS-1] <= '0;
                        wid_q[NUM_SLOTS-1]  <= ID_NONE;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_done_d) begin
                        state_q <= ST_ZCALC;
                    end else begin
                        rom_addr_q <= ptr_q;
                        wait_q     <= '0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (wait_q != WAIT_W'(ROM_LATENCY)) begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end else if (fits_d) begin
                        slot_q[cnt_q] <= rom_rec_d;
                        wid_q[cnt_q]  <= ptr_q;
                        ptr_q <= ptr_inc_d;
                        cnt_q <= cnt_inc_d;
                        // Chain the next read straight away while room remains.
                        if ((cnt_inc_d != CNT_W'(NUM_SLOTS)) &&
                            (ptr_inc_d != 8'(NUM_BLOCKS))) begin
                            rom_addr_q <= ptr_inc_d;
                            wait_q     <= '0;
                        end else begin
                            state_q <= ST_ZCALC;
                        end
                    end else begin
                        state_q <= ST_ZCALC;
                    end
                end
                ST_ZCALC: begin
                    if (zlive_d) begin
                        stg_x_q[zidx_q]   <= zsel_d.x;
                        stg_y_q[zidx_q]   <= zsel_d.y;
                        stg_z_q[zidx_q]   <= z_d;
                        stg_c_q[zidx_q]   <= zsel_d.color;
                        stg_d_q[zidx_q]   <= zsel_d.dir;
                        stg_id_q[zidx_q]  <= wid_q[zidx_q];
                        stg_vis_q[zidx_q] <= 1'b1;
                    end else begin
                        stg_x_q[zidx_q]   <= '0;
                        stg_y_q[zidx_q]   <= '0;
                        stg_z_q[zidx_q]   <= '0;
                        stg_c_q[zidx_q]   <= 1'b0;
                        stg_d_q[zidx_q]   <= '0;
                        stg_id_q[zidx_q]  <= ID_NONE;
                        stg_vis_q[zidx_q] <= 1'b0;
                    end
                    if (zidx_q == CNT_W'(NUM_SLOTS - 1)) begin
                        zidx_q  <= '0;
                        state_q <= ST_COMMIT;
                    end else begin
                        zidx_q <= zidx_q + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    pub_x_q   <= stg_x_q;
                    pub_y_q   <= stg_y_q;
                    pub_z_q   <= stg_z_q;
                    pub_c_q   <= stg_c_q;
                    pub_d_q   <= stg_d_q;
                    pub_id_q  <= stg_id_q;
                    pub_vis_q <= stg_vis_q;
                    wvalid_q  <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sliced_id_list u_sliced (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .restart_in     (restart_in),
        .slice_valid_in (slice_valid_in),
        .slice_id_in    (slice_ID_in),
        .list_out       (sliced_blocks_out)
    );

    assign rom_addr_out        = rom_addr_q;
    assign block_x_out         = pub_x_q;
    assign block_y_out         = pub_y_q;
    assign block_z_out         = pub_z_q;
    assign block_color_out     = pub_c_q;
    assign block_direction_out = pub_d_q;
    assign block_ID_out        = pub_id_q;
    assign block_visible_out   = pub_vis_q;
    assign busy_out            = busy_q;
    assign window_valid_out    = wvalid_q;

endmodule

// File: tb/tb_block_window_loader.sv
// Scoreboard bench for block_window_loader: expected windows are queued
// at frame_start and checked by a monitor on window_valid_out.
module tb_block_window_loader;
    import block_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        restart_in = 1'b0;
    logic [17:0] curr_time_in = '0;
    logic        slice_valid_in = 1'b0;
    logic [7:0]  slice_ID_in = '0;
    logic [7:0]  rom_addr_out;
    logic [45:0] rom_data_in = '0;
    logic [11:0][11:0] block_x_out;
    logic [11:0][11:0] block_y_out;
    logic [11:0][13:0] block_z_out;
    logic [11:0]       block_color_out;
    logic [11:0][2:0]  block_direction_out;
    logic [11:0][7:0]  block_ID_out;
    logic [11:0]       block_visible_out;
    logic [11:0][7:0]  sliced_blocks_out;
    logic        busy_out;
    logic        window_valid_out;

    typedef struct packed {
        logic [11:0][11:0] x;
        logic [11:0][11:0] y;
        logic [11:0][13:0] z;
        logic [11:0]       c;
        logic [11:0][2:0]  d;
        logic [11:0][7:0]  id;
        logic [11:0]       vis;
    } win_t;

    win_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [45:0] rom_mem [256];
    logic [45:0] rom_s1 = '0;

    block_window_loader dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .frame_start_in      (frame_start_in),
        .restart_in          (restart_in),
        .curr_time_in        (curr_time_in),
        .slice_valid_in      (slice_valid_in),
        .slice_ID_in         (slice_ID_in),
        .rom_addr_out        (rom_addr_out),
        .rom_data_in         (rom_data_in),
        .block_x_out         (block_x_out),
        .block_y_out         (block_y_out),
        .block_z_out         (block_z_out),
        .block_color_out     (block_color_out),
        .block_direction_out (block_direction_out),
        .block_ID_out        (block_ID_out),
        .block_visible_out   (block_visible_out),
        .sliced_blocks_out   (sliced_blocks_out),
        .busy_out            (busy_out),
        .window_valid_out    (window_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-stage ROM model: data valid two cycles after the address.
    always @(posedge clk_in) begin
        rom_s1      <= rom_mem[rom_addr_out];
        rom_data_in <= rom_s1;
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [45:0] rom_word(input int t, input int k);
        logic [11:0] kk;
        kk = 12'(k);
        return {18'(t), 12'h100 + kk, 12'h200 + kk, kk[0], kk[2:0]};
    endfunction

    function automatic win_t empty_win();
        win_t r;
        r    = '0;
        r.id = {12{8'hFF}};
        return r;
    endfunction

    function automatic win_t set_slot(input win_t w, input int s,
                                      input int k, input int z);
        win_t r;
        logic [11:0] kk;
        r  = w;
        kk = 12'(k);
        r.x[s]   = 12'h100 + kk;
        r.y[s]   = 12'h200 + kk;
        r.z[s]   = 14'(z);
        r.c[s]   = kk[0];
        r.d[s]   = kk[2:0];
        r.id[s]  = 8'(k);
        r.vis[s] = 1'b1;
        return r;
    endfunction

    // Monitor: every published window must match the oldest expectation.
    always @(negedge clk_in) begin
        win_t e;
        if (rst_n_in && window_valid_out) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_window: got window_valid=1 expected none");
            end else begin
                e = exp_q.pop_front();
                chk("win_x",   256'(block_x_out),         256'(e.x));
                chk("win_y",   256'(block_y_out),         256'(e.y));
                chk("win_z",   256'(block_z_out),         256'(e.z));
                chk("win_col", 256'(block_color_out),     256'(e.c));
                chk("win_dir", 256'(block_direction_out), 256'(e.d));
                chk("win_id",  256'(block_ID_out),        256'(e.id));
                chk("win_vis", 256'(block_visible_out),   256'(e.vis));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},   256'(busy_out),          256'(0));
        chk({tag, "_wvalid"}, 256'(window_valid_out),  256'(0));
        chk({tag, "_addr"},   256'(rom_addr_out),      256'(0));
        chk({tag, "_x"},      256'(block_x_out),       256'(0));
        chk({tag, "_z"},      256'(block_z_out),       256'(0));
        chk({tag, "_vis"},    256'(block_visible_out), 256'(0));
        chk({tag, "_id"},     256'(block_ID_out),      256'({12{8'hFF}}));
        chk({tag, "_sliced"}, 256'(sliced_blocks_out), 256'({12{8'hFF}}));
    endtask

    task automatic frame(input int t, input win_t e);
        @(negedge clk_in);
        curr_time_in   = 18'(t);
        frame_start_in = 1'b1;
        exp_q.push_back(e);
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 120) begin
            @(negedge clk_in);
            k++;
        end
        chk({nm, "_timeout"}, 256'(exp_q.size()), 256'(0));
        exp_q.delete();
    endtask

    task automatic pulse_restart();
        @(negedge clk_in);
        restart_in = 1'b1;
        @(negedge clk_in);
        restart_in = 1'b0;
    endtask

    task automatic slice(input logic [7:0] id);
        @(negedge clk_in);
        slice_valid_in = 1'b1;
        slice_ID_in    = id;
        @(negedge clk_in);
        slice_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        win_t w2, w3, w4a, w4b, wc;
        logic [11:0][7:0] lst;

        w2 = empty_win();
        w2 = set_slot(w2, 0, 0, 200);
        w2 = set_slot(w2, 1, 1, 400);
        w2 = set_slot(w2, 2, 2, 600);
        w3 = empty_win();
        w3 = set_slot(w3, 0, 1, 100);
        w3 = set_slot(w3, 1, 2, 300);
        w4a = empty_win();
        w4b = empty_win();
        for (int s = 0; s < 12; s++) begin
            w4a = set_slot(w4a, s, s, 20 * s);
            w4b = set_slot(w4b, s, s + 3, 10 + 20 * s);
        end
        wc = empty_win();
        wc = set_slot(wc, 0, 0, 0);
        wc = set_slot(wc, 1, 1, 8192);

        for (int i = 0; i < 256; i++) rom_mem[i] = rom_word(18'h3FFFF, i);
        rom_mem[0] = rom_word(100, 0);
        rom_mem[1] = rom_word(200, 1);
        rom_mem[2] = rom_word(300, 2);

        repeat (2) @(negedge clk_in);
        check_reset("por");
        rst_n_in = 1'b1;

        // Reset asserted while the update is fetching from ROM.
        @(negedge clk_in);
        curr_time_in   = 18'd0;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("busy_mid_fill", 256'(busy_out), 256'(1));
        #1 rst_n_in = 1'b0;
        #1 check_reset("mid_fill_rst");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        frame(0, w2);
        wait_drain("t0");
        frame(150, w3);
        wait_drain("t150");

        pulse_restart();
        for (int i = 0; i < 20; i++) rom_mem[i] = rom_word(1000 + 10 * i, i);
        frame(1000, w4a);
        wait_drain("full12");
        chk("last_fetch_11", 256'(rom_addr_out), 256'(11));
        frame(1025, w4b);
        wait_drain("refill");
        chk("last_fetch_14", 256'(rom_addr_out), 256'(14));

        slice(8'd5);
        slice(8'd5);
        slice(8'd7);
        lst = {12{8'hFF}};
        lst[0] = 8'd5;
        lst[1] = 8'd7;
        chk("sliced_dedup", 256'(sliced_blocks_out), 256'(lst));
        for (int i = 20; i < 32; i++) slice(8'(i));
        lst[0] = 8'd30;
        lst[1] = 8'd31;
        for (int i = 2; i < 12; i++) lst[i] = 8'(18 + i);
        chk("sliced_wrap", 256'(sliced_blocks_out), 256'(lst));

        // Second frame_start while busy must not start another update.
        frame(1025, w4b);
        @(negedge clk_in);
        curr_time_in   = 18'd5000;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        wait_drain("busy_ignore");
        repeat (80) @(negedge clk_in);

        // Restart while z values are being computed.
        @(negedge clk_in);
        curr_time_in   = 18'd1025;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("busy_in_zcalc", 256'(busy_out), 256'(1));
        restart_in     = 1'b1;
        slice_valid_in = 1'b1;
        slice_ID_in    = 8'd40;
        @(negedge clk_in);
        restart_in     = 1'b0;
        slice_valid_in = 1'b0;
        chk("restart_busy", 256'(busy_out), 256'(0));
        chk("restart_sliced", 256'(sliced_blocks_out), 256'({12{8'hFF}}));
        chk("restart_keep_ids", 256'(block_ID_out), 256'(w4b.id));
        repeat (80) @(negedge clk_in);
        chk("restart_idle", 256'(busy_out), 256'(0));

        frame(1000, w4a);
        wait_drain("after_restart");

        pulse_restart();
        rom_mem[0] = rom_word(5000, 0);
        rom_mem[1] = rom_word(9096, 1);
        rom_mem[2] = rom_word(9097, 2);
        frame(5000, wc);
        wait_drain("horizon");

        repeat (5) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
